rot_shaft_decoder: RTL and testbench

- Upstream front end for the rotary-shaft operand-entry path. Takes raw quadrature pins rota/rotb and synchronises and debounces them.
- Decodes detent transitions into a one-cycle rot_event pulse with direction.
- Also provides a level-style rot_level and a wrapping position count, for the nibble-loading add/sub datapath and for LED display.

---
 rtl/rot_shaft_if.sv | 21 ++
 rtl/rot_shaft_decoder.sv | 83 ++++++++
 tb/tb_rot_shaft_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rot_shaft_if.sv
// rot_shaft_if: shaft pins in, decoded event/level/position out
interface rot_shaft_if #(
    parameter int POS_WIDTH = 4
);
    logic                 rota;
    logic                 rotb;
    logic                 rot_event;
    logic                 rot_left;
    logic                 rot_level;
    logic [POS_WIDTH-1:0] position;

    modport master (
        output rota, rotb,
        input  rot_event, rot_left, rot_level, position
    );

    modport slave (
        input  rota, rotb,
        output rot_event, rot_left, rot_level, position
    );
endinterface

// File: rtl/rot_shaft_decoder.sv
// rot_shaft_decoder: debounced quadrature decoder producing detent events, level and position
module rot_shaft_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int POS_WIDTH = 4
) (
    input logic clk,
    input logic reset,
    rot_shaft_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

    logic [1:0]    m, s, deb, fill;
    logic [CW-1:0] cnt [2];
    logic          q1, q2, q1_d, armed, step;

    assign step = q1 & ~q1_d & armed;

    // Two-flop synchronisers (bit 0 = A, bit 1 = B); fill marks when s holds real pin data
    // rather than reset zeros, so arming cannot be fooled by the cleared pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m    <= '0;
            s    <= '0;
            fill <= '0;
        end else begin
            m    <= {bus.rotb, bus.rota};
            s    <= m;
            fill <= {fill[0], 1'b1};
        end
    end

    // Per-input debounce: accept a new level only after it persists DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb    <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= s[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + CNT_ONE;
            end
        end
    end

    // Detent state: q1 tracks 11/00 detents, q2 remembers which phase led, armed after a real 00
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1    <= 1'b0;
            q2    <= 1'b0;
            q1_d  <= 1'b0;
            armed <= 1'b0;
        end else begin
            q1    <= (deb == 2'b11) ? 1'b1 : (deb == 2'b00) ? 1'b0 : q1;
            q2    <= (deb == 2'b10) ? 1'b1 : (deb == 2'b01) ? 1'b0 : q2;
            q1_d  <= q1;
            armed <= armed | (fill[1] & (deb == 2'b00) & (s == 2'b00));
        end
    end

    // Registered outputs: one-cycle event on q1 rising, direction and wrapping position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rot_event <= 1'b0;
            bus.rot_left  <= 1'b0;
            bus.rot_level <= 1'b0;
            bus.position  <= '0;
        end else begin
            bus.rot_event <= step;
            bus.rot_level <= q1;
            if (step) begin
                bus.rot_left <= q2;
                bus.position <= q2 ? bus.position - POS_ONE : bus.position + POS_ONE;
            end
        end
    end
endmodule

// File: tb/tb_rot_shaft_decoder.sv
// tb_rot_shaft_decoder: directed checks of debounce, decode, wrap, arming and async reset
module tb_rot_shaft_decoder;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   ev = 0;
    int   base;
    int   n;

    rot_shaft_if #(.POS_WIDTH(4)) bus ();

    rot_shaft_decoder #(.DEBOUNCE_CYCLES(4), .POS_WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count event pulses just after each rising edge
    always @(posedge clk) begin
        #1;
        if (bus.rot_event) ev++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic a, input logic b, input int cyc);
        bus.rota = a;
        bus.rotb = b;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic wait_event(output int cnt);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            cnt++;
            if (bus.rot_event) break;
        end
    endtask

    task automatic right_step();
        hold(0, 0, 10);
        hold(1, 0, 10);
        hold(1, 1, 10);
    endtask

    task automatic left_step();
        hold(0, 0, 10);
        hold(0, 1, 10);
        hold(1, 1, 10);
    endtask

    function automatic logic [6:0] outs();
        return {bus.rot_event, bus.rot_left, bus.rot_level, bus.position};
    endfunction

    initial begin
        reset = 1'b1;
        bus.rota = 1'b0;
        bus.rotb = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'd0);
        reset = 1'b0;

        hold(0, 0, 10);
        hold(1, 0, 10);
        bus.rota = 1'b1;
        bus.rotb = 1'b1;
        wait_event(n);
        chk("right_latency", n, 8);
        @(negedge clk);
        chk("pulse_one_cycle", 32'(bus.rot_event), 0);
        hold(1, 1, 8);
        chk("right_count", ev, 1);
        chk("right_dir", 32'(bus.rot_left), 0);
        chk("right_pos", 32'(bus.position), 1);
        chk("right_level", 32'(bus.rot_level), 1);

        left_step();
        chk("left_count", ev, 2);
        chk("left_dir", 32'(bus.rot_left), 1);
        chk("left_pos", 32'(bus.position), 0);
        left_step();
        chk("left_wrap_pos", 32'(bus.position), 15);
        right_step();
        chk("right_wrap_pos", 32'(bus.position), 0);
        chk("right_after_left_dir", 32'(bus.rot_left), 0);
        for (int i = 0; i < 16; i++) right_step();
        chk("sixteen_rights_pos", 32'(bus.position), 0);
        chk("sixteen_rights_count", ev, 20);

        hold(0, 0, 10);
        chk("level_low_at_00", 32'(bus.rot_level), 0);
        hold(1, 0, 2);
        hold(0, 0, 2);
        hold(1, 0, 2);
        hold(0, 0, 2);
        hold(1, 0, 10);
        hold(1, 1, 10);
        chk("bounce_count", ev, 21);
        chk("bounce_pos", 32'(bus.position), 1);
        chk("bounce_dir", 32'(bus.rot_left), 0);

        hold(1, 1, 100);
        hold(1, 0, 10);
        hold(1, 1, 10);
        chk("reversal_count", ev, 21);
        chk("reversal_pos", 32'(bus.position), 1);

        reset = 1'b1;
        hold(1, 1, 3);
        reset = 1'b0;
        hold(1, 1, 50);
        chk("high_at_reset_count", ev, 21);
        chk("high_at_reset_pos", 32'(bus.position), 0);
        chk("high_at_reset_level", 32'(bus.rot_level), 1);
        hold(0, 0, 10);
        hold(1, 1, 10);
        chk("armed_direct_count", ev, 22);
        chk("armed_direct_pos", 32'(bus.position), 1);
        chk("armed_direct_dir", 32'(bus.rot_left), 0);

        bus.rota = 1'b0;
        bus.rotb = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_mid_debounce", 32'(outs()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        hold(0, 0, 10);
        bus.rota = 1'b1;
        bus.rotb = 1'b1;
        wait_event(n);
        chk("direct_latency", n, 8);
        chk("direct_pos", 32'(bus.position), 1);
        reset = 1'b1;
        #1;
        chk("reset_on_event", 32'(outs()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        base = ev;
        hold(1, 1, 30);
        chk("no_event_unarmed", ev - base, 0);
        chk("no_event_unarmed_pos", 32'(bus.position), 0);
        hold(0, 0, 10);
        hold(1, 1, 10);
        chk("rearmed_count", ev - base, 1);
        chk("rearmed_pos", 32'(bus.position), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
